// File: rtl/imem_responder.sv
// Word-addressed 32-bit RAM behind a valid/ready request/response handshake,
// with a fixed access latency, byte-strobed writes and misalign/range errors.
//
// state | meaning
// IDLE  | req_ready high, waiting for a request
// WAIT  | request latched, counting down the access latency
// RESP  | response presented, held until rsp_ready
module imem_responder #(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic        req_we,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wstrb,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int          IW       = $clog2(DEPTH);
  localparam logic [31:0] DEPTH_W  = 32'(DEPTH);
  localparam logic [3:0]  CNT_LOAD = 4'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic [31:0] l_addr;
  logic [31:0] l_wdata;
  logic        l_we;
  logic [3:0]  l_wstrb;
  logic [31:0] mem [DEPTH];

  logic          accept;
  logic          enter_resp;
  logic          direct;
  logic [31:0]   a_addr;
  logic [31:0]   a_wdata;
  logic          a_we;
  logic [3:0]    a_wstrb;
  logic          a_err;
  logic [IW-1:0] a_idx;

  assign accept = (state == IDLE) && req_valid && req_ready;

  // With single-cycle latency the access happens on the accept edge itself,
  // so the live request fields feed the RAM instead of the latched copies.
  always_comb begin
    direct     = (LATENCY == 1) && (state == IDLE);
    a_addr     = direct ? req_addr  : l_addr;
    a_wdata    = direct ? req_wdata : l_wdata;
    a_we       = direct ? req_we    : l_we;
    a_wstrb    = direct ? req_wstrb : l_wstrb;
    enter_resp = (LATENCY == 1) ? accept : ((state == WAIT) && (cnt == 4'd1));
    a_err      = (a_addr[1:0] != 2'b00) || ({2'b00, a_addr[31:2]} >= DEPTH_W);
    a_idx      = a_addr[IW+1:2];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b0;
      l_addr    <= 32'd0;
      l_wdata   <= 32'd0;
      l_we      <= 1'b0;
      l_wstrb   <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          req_ready <= 1'b1;
          if (accept) begin
            req_ready <= 1'b0;
            l_addr    <= req_addr;
            l_wdata   <= req_wdata;
            l_we      <= req_we;
            l_wstrb   <= req_wstrb;
            if (LATENCY == 1) begin
              state <= RESP;
            end else begin
              cnt   <= CNT_LOAD;
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) state <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      if (enter_resp) begin
        rsp_valid <= 1'b1;
        rsp_err   <= a_err;
        rsp_rdata <= (a_we || a_err) ? 32'd0 : mem[a_idx];
      end
    end
  end

  // RAM contents survive reset; writes commit only on the edge entering RESP.
  always_ff @(posedge clk) begin
    if (enter_resp && a_we && !a_err) begin
      for (int i = 0; i < 4; i++) begin
        if (a_wstrb[i]) mem[a_idx][8*i +: 8] <= a_wdata[8*i +: 8];
      end
    end
  end

endmodule
